// File: rtl/cep_decoder_pkg.sv
// CEP decoder shared definitions: CEP package field ranges,
// NoC flit layouts and the length-correction helpers.
package cep_decoder_pkg;

  localparam int CEP_WORD_WIDTH = 64;
  localparam int CEP_WORDS      = 8;
  localparam int CEP_DATA_WIDTH = CEP_WORD_WIDTH * CEP_WORDS;
  localparam int CEP_MAX_LEN    = 7;
  localparam int CEP_MIN_REQ_LEN = 2;
  localparam int CEP_LEN_W      = 4;

  // word 0 of the CEP package
  localparam int CEP_ISREQ      = 63;
  localparam int CEP_LEN_HI     = 62;
  localparam int CEP_LEN_LO     = 59;
  localparam int CEP_TYPE_HI    = 58;
  localparam int CEP_TYPE_LO    = 51;
  localparam int CEP_MSHR_HI    = 50;
  localparam int CEP_MSHR_LO    = 43;
  localparam int CEP_MESI_HI    = 42;
  localparam int CEP_MESI_LO    = 41;
  localparam int CEP_LASTSL     = 40;
  localparam int CEP_SLID_HI    = 39;
  localparam int CEP_SLID_LO    = 38;
  localparam int CEP_CTYPE      = 37;
  localparam int CEP_SLVEC_HI   = 36;
  localparam int CEP_SLVEC_LO   = 33;
  localparam int CEP_DSIZE_HI   = 32;
  localparam int CEP_DSIZE_LO   = 30;
  localparam int CEP_SRC_HI     = 29;
  localparam int CEP_SRC_LO     = 16;
  // word 1 of a request
  localparam int CEP_ADDR_HI    = 39;
  localparam int CEP_ADDR_LO    = 0;

  localparam int NOC_FLIT_W     = 64;
  localparam int NOC_CHIPID_W   = 14;
  localparam int NOC_XY_W       = 8;
  localparam int NOC_FBITS_W    = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  typedef struct packed {
    logic [NOC_CHIPID_W-1:0] dst_chipid;
    logic [NOC_XY_W-1:0]     dst_x;
    logic [NOC_XY_W-1:0]     dst_y;
    logic [NOC_FBITS_W-1:0]  dst_fbits;
    logic [7:0]              len;
    logic [7:0]              typ;
    logic [7:0]              mshrid;
    logic [1:0]              mesi;
    logic                    last_sl;
    logic [1:0]              sl_id;
    logic                    rsvd;
  } noc_hdr_t;

  typedef struct packed {
    logic [47:0] addr;
    logic [3:0]  sl_vec;
    logic        ctype;
    logic [7:0]  rsvd;
    logic [2:0]  dsize;
  } noc_req1_t;

  typedef struct packed {
    logic [NOC_CHIPID_W-1:0] src_chipid;
    logic [NOC_XY_W-1:0]     src_x;
    logic [NOC_XY_W-1:0]     src_y;
    logic [NOC_FBITS_W-1:0]  src_fbits;
    logic [29:0]             rsvd;
  } noc_req2_t;

  function automatic logic cep_len_bad(
    input logic                 is_req,
    input logic [CEP_LEN_W-1:0] len
  );
    return (len > CEP_LEN_W'(CEP_MAX_LEN)) ||
           (is_req && len < CEP_LEN_W'(CEP_MIN_REQ_LEN));
  endfunction

  function automatic logic [2:0] cep_eff_len(
    input logic                 is_req,
    input logic [CEP_LEN_W-1:0] len
  );
    if (len > CEP_LEN_W'(CEP_MAX_LEN))
      return 3'(CEP_MAX_LEN);
    if (is_req && len < CEP_LEN_W'(CEP_MIN_REQ_LEN))
      return 3'(CEP_MIN_REQ_LEN);
    return len[2:0];
  endfunction

endpackage

// File: rtl/cep_decoder.sv
// CEP package to NoC flit serializer: holds one package and
// streams header, request flits and data words downstream.
module cep_decoder
  import cep_decoder_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cep_pkg_val,
  input  logic [CEP_DATA_WIDTH-1:0] cep_pkg,
  output logic                      cep_pkg_rdy,
  input  logic [NOC_CHIPID_W-1:0]   dst_chipid,
  input  logic [NOC_XY_W-1:0]       dst_x,
  input  logic [NOC_XY_W-1:0]       dst_y,
  input  logic [NOC_FBITS_W-1:0]    dst_fbits,
  output logic                      noc_val,
  output logic [NOC_FLIT_W-1:0]     noc_data,
  input  logic                      noc_rdy,
  output logic                      len_err
);

  state_e r_state;
  state_e w_state_nxt;

  logic [CEP_WORDS-1:0][CEP_WORD_WIDTH-1:0] r_pkg;
  logic [2:0]              r_idx;
  logic [2:0]              r_len;
  logic                    r_len_err;
  logic [NOC_CHIPID_W-1:0] r_dst_chipid;
  logic [NOC_XY_W-1:0]     r_dst_x;
  logic [NOC_XY_W-1:0]     r_dst_y;
  logic [NOC_FBITS_W-1:0]  r_dst_fbits;

  logic      w_accept;
  logic      w_hs;
  logic      w_last;
  logic      w_is_req;
  logic      w_in_req;
  logic [CEP_LEN_W-1:0] w_in_len;
  noc_hdr_t  w_flit0;
  noc_req1_t w_flit1;
  noc_req2_t w_flit2;

  assign w_in_req = cep_pkg[CEP_ISREQ];
  assign w_in_len = cep_pkg[CEP_LEN_HI:CEP_LEN_LO];
  assign w_accept = cep_pkg_val && cep_pkg_rdy;
  assign w_hs     = noc_val && noc_rdy;
  assign w_last   = (r_idx == r_len);
  assign w_is_req = r_pkg[0][CEP_ISREQ];
  assign len_err  = r_len_err;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_SEND;
      ST_SEND: if (w_hs && w_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cep_pkg_rdy = 1'b0;
    noc_val     = 1'b0;
    unique case (r_state)
      ST_IDLE: cep_pkg_rdy = rst_n;
      ST_SEND: noc_val     = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pkg        <= '0;
      r_idx        <= '0;
      r_len        <= '0;
      r_len_err    <= 1'b0;
      r_dst_chipid <= '0;
      r_dst_x      <= '0;
      r_dst_y      <= '0;
      r_dst_fbits  <= '0;
    end else begin
      r_len_err <= 1'b0;
      if (w_accept) begin
        r_pkg        <= cep_pkg;
        r_idx        <= '0;
        r_len        <= cep_eff_len(w_in_req, w_in_len);
        r_len_err    <= cep_len_bad(w_in_req, w_in_len);
        r_dst_chipid <= dst_chipid;
        r_dst_x      <= dst_x;
        r_dst_y      <= dst_y;
        r_dst_fbits  <= dst_fbits;
      end else if (w_hs) begin
        r_idx <= r_idx + 3'd1;
      end
    end
  end

  always_comb begin
    w_flit0            = '0;
    w_flit0.dst_chipid = r_dst_chipid;
    w_flit0.dst_x      = r_dst_x;
    w_flit0.dst_y      = r_dst_y;
    w_flit0.dst_fbits  = r_dst_fbits;
    w_flit0.len        = 8'(r_len);
    w_flit0.typ        = r_pkg[0][CEP_TYPE_HI:CEP_TYPE_LO];
    w_flit0.mshrid     = r_pkg[0][CEP_MSHR_HI:CEP_MSHR_LO];
    w_flit0.mesi       = r_pkg[0][CEP_MESI_HI:CEP_MESI_LO];
    w_flit0.last_sl    = r_pkg[0][CEP_LASTSL];
    w_flit0.sl_id      = r_pkg[0][CEP_SLID_HI:CEP_SLID_LO];

    w_flit1        = '0;
    w_flit1.addr   = 48'(r_pkg[1][CEP_ADDR_HI:CEP_ADDR_LO]);
    w_flit1.sl_vec = r_pkg[0][CEP_SLVEC_HI:CEP_SLVEC_LO];
    w_flit1.ctype  = r_pkg[0][CEP_CTYPE];
    w_flit1.dsize  = r_pkg[0][CEP_DSIZE_HI:CEP_DSIZE_LO];

    w_flit2            = '0;
    w_flit2.src_chipid = r_pkg[0][CEP_SRC_HI:CEP_SRC_LO];
  end

  // words 1 and 2 of a request carry fields, not payload
  always_comb begin
    noc_data = r_pkg[r_idx];
    unique case (1'b1)
      (r_idx == 3'd0):             noc_data = w_flit0;
      (w_is_req && r_idx == 3'd1): noc_data = w_flit1;
      (w_is_req && r_idx == 3'd2): noc_data = w_flit2;
      default: ;
    endcase
  end

endmodule
